uart_reg_loader: RTL and testbench

- Parametrised successor to the fixed 9600-baud UART-to-APU register path.
- Receives 8N1 serial bytes using N-times oversampling, start-glitch rejection and framing-error detection.
- Decodes each byte as a nibble write, {nibble_addr[3:0], nibble_data[3:0]}, and assembles nibbles into an 8-bit register file of NUM_REGS entries.
- Sits between the board RX pin and the sound core's register inputs. It replaces the ad-hoc receiver in fpga_top.

---
 rtl/uart_reg_loader_pkg.sv | 38 +++
 rtl/uart_reg_loader_if.sv | 28 ++
 rtl/uart_reg_loader_rx.sv | 131 +++++++++++++
 rtl/uart_reg_loader.sv | 114 +++++++++++
 tb/tb_uart_reg_loader.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_reg_loader_pkg.sv
// Shared definitions for the UART register loader.
//   - calc_div / calc_timeout_ticks: derive prescaler divide and timeout
//     length from the module parameters.
//   - rx_state_t: receiver FSM states.
//   - Nibble field positions inside a received command byte.
`timescale 1ns/1ps
package uart_reg_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Command byte layout: {nibble_addr[3:0], nibble_data[3:0]}.
    // nibble_addr[3:1] selects the register, nibble_addr[0] selects hi/lo.
    localparam int unsigned NIB_ADDR_MSB = 7;
    localparam int unsigned NIB_ADDR_LSB = 4;
    localparam int unsigned NIB_DATA_MSB = 3;
    localparam int unsigned NIB_DATA_LSB = 0;

    // Clocks per oversample tick, truncated; never allowed to reach zero.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned d;
        d = clk_hz / (baud * os);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int unsigned calc_timeout_ticks(input int unsigned bits,
                                                       input int unsigned os);
        return bits * os;
    endfunction

endpackage

// File: rtl/uart_reg_loader_if.sv
// Board-side bundle of the UART register loader.
//   rx         : serial input, idle high (driven by the board / master)
//   regs       : flattened register file, reg i = regs[8*i+7:8*i]
//   wr_stb     : one-cycle pulse on the cycle reg i is updated
//   byte_valid : one-cycle pulse, byte_data holds a good byte
//   byte_data  : last good received byte
//   frame_err  : one-cycle pulse, stop bit sampled low
`timescale 1ns/1ps
interface uart_reg_loader_if #(
    parameter int unsigned NUM_REGS = 8
);
    logic                  rx;
    logic [NUM_REGS*8-1:0] regs;
    logic [NUM_REGS-1:0]   wr_stb;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  frame_err;

    modport master (
        output rx,
        input  regs, wr_stb, byte_valid, byte_data, frame_err
    );

    modport slave (
        input  rx,
        output regs, wr_stb, byte_valid, byte_data, frame_err
    );
endinterface

// File: rtl/uart_reg_loader_rx.sv
// 8N1 oversampling UART receiver.
//   clk, rst_n   : system clock, async active-low reset
//   rx_i         : asynchronous serial input (synchronised here)
//   tick_o       : oversample tick, also used by the loader's timeout
//   byte_valid_o : one-cycle pulse with byte_data_o holding the byte
//   byte_data_o  : last good byte
//   frame_err_o  : one-cycle pulse when the stop bit is sampled low
`timescale 1ns/1ps
module uart_rx_os
    import uart_reg_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 12_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       tick_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);
    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        state_q;
    logic [DIV_W-1:0] div_q;
    logic [OS_W-1:0]  os_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             byte_valid_q;
    logic [7:0]       byte_data_q;
    logic             frame_err_q;
    logic             tick;
    logic             start_edge;

    assign tick       = (div_q == DIV_LAST);
    assign start_edge = (state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= RX_IDLE;
            div_q        <= '0;
            os_q         <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx_i;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            // Free-running so the timeout sees ticks while idle; realigned
            // to each start edge so samples land mid-bit.
            if (tick || start_edge) div_q <= '0;
            else                    div_q <= div_q + DIV_W'(1);

            case (state_q)
                RX_IDLE: begin
                    if (start_edge) begin
                        state_q <= RX_START;
                        os_q    <= '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (os_q == HALF_LAST) begin
                            os_q    <= '0;
                            bit_q   <= '0;
                            state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                        end else begin
                            os_q <= os_q + OS_W'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (os_q == OS_LAST) begin
                            os_q    <= '0;
                            shift_q <= {rx_sync_q, shift_q[7:1]};
                            if (bit_q == 3'd7) state_q <= RX_STOP;
                            else               bit_q   <= bit_q + 3'd1;
                        end else begin
                            os_q <= os_q + OS_W'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (os_q == OS_LAST) begin
                            os_q <= '0;
                            if (rx_sync_q) begin
                                byte_data_q  <= shift_q;
                                byte_valid_q <= 1'b1;
                                state_q      <= RX_IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= RX_WAIT_HIGH;
                            end
                        end else begin
                            os_q <= os_q + OS_W'(1);
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync_q) state_q <= RX_IDLE;
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign tick_o       = tick;
    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/uart_reg_loader.sv
// UART-to-register loader: receives nibble-write bytes and assembles them
// into an 8-bit register file.
//   clk, rst_n : system clock, async active-low reset
//   bus        : slave side of uart_reg_loader_if (rx in; regs, wr_stb,
//                byte_valid, byte_data, frame_err out)
`timescale 1ns/1ps
module uart_reg_loader
    import uart_reg_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 12_000_000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned NUM_REGS     = 8,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_reg_loader_if.slave bus
);
    localparam int unsigned TIMEOUT_TICKS = calc_timeout_ticks(TIMEOUT_BITS, OVERSAMPLE);
    localparam int unsigned TO_W          = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);

    logic                tick;
    logic                rx_valid;
    logic [7:0]          rx_byte;
    logic                rx_ferr;

    logic [7:0]          regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_stb_q;
    logic [3:0]          staged_lo_q;
    logic [2:0]          staged_idx_q;
    logic                staged_valid_q;
    logic [TO_W-1:0]     to_q;

    logic [3:0]          addr;
    logic [3:0]          nib;
    logic [2:0]          idx;
    logic                idx_ok;

    uart_rx_os #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (bus.rx),
        .tick_o       (tick),
        .byte_valid_o (rx_valid),
        .byte_data_o  (rx_byte),
        .frame_err_o  (rx_ferr)
    );

    assign addr   = rx_byte[NIB_ADDR_MSB:NIB_ADDR_LSB];
    assign nib    = rx_byte[NIB_DATA_MSB:NIB_DATA_LSB];
    assign idx    = addr[3:1];
    assign idx_ok = (32'(idx) < NUM_REGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q         <= '{default: '0};
            wr_stb_q       <= '0;
            staged_lo_q    <= '0;
            staged_idx_q   <= '0;
            staged_valid_q <= 1'b0;
            to_q           <= '0;
        end else begin
            wr_stb_q <= '0;
            // A byte takes priority over a coincident timeout expiry.
            if (rx_valid) begin
                to_q <= '0;
                if (idx_ok) begin
                    if (!addr[0]) begin
                        staged_lo_q    <= nib;
                        staged_idx_q   <= idx;
                        staged_valid_q <= 1'b1;
                    end else begin
                        staged_valid_q <= 1'b0;
                        if (staged_valid_q && (staged_idx_q == idx)) begin
                            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                                if (i == 32'(idx)) begin
                                    regs_q[i]   <= {nib, staged_lo_q};
                                    wr_stb_q[i] <= 1'b1;
                                end
                            end
                        end
                    end
                end
            end else if (rx_ferr) begin
                staged_valid_q <= 1'b0;
            end else if (!staged_valid_q) begin
                to_q <= '0;
            end else if (tick) begin
                if (to_q == TO_LAST) begin
                    staged_valid_q <= 1'b0;
                    to_q           <= '0;
                end else begin
                    to_q <= to_q + TO_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign bus.regs[8*g +: 8] = regs_q[g];
    end

    assign bus.wr_stb     = wr_stb_q;
    assign bus.byte_valid = rx_valid;
    assign bus.byte_data  = rx_byte;
    assign bus.frame_err  = rx_ferr;

endmodule

// File: tb/tb_uart_reg_loader.sv
// Scoreboard bench for uart_reg_loader. Runs an 8-register instance and a
// 4-register instance on a shared rx line at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_reg_loader;

    localparam int unsigned BAUD   = 9600;
    localparam int unsigned OS     = 8;
    localparam int unsigned DIVC   = 2;
    localparam int unsigned CLK_HZ = BAUD * OS * DIVC;
    localparam int unsigned BITCLK = OS * DIVC;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_reg_loader_if #(.NUM_REGS(8)) bus8 ();
    uart_reg_loader_if #(.NUM_REGS(4)) bus4 ();
    assign bus4.rx = bus8.rx;

    uart_reg_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .NUM_REGS(8), .TIMEOUT_BITS(20)
    ) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    uart_reg_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .NUM_REGS(4), .TIMEOUT_BITS(20)
    ) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef enum {EV_BV, EV_FE, EV_WR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int unsigned idx;
        logic [7:0]  data;
    } ev_t;

    ev_t         exp_q[$];
    logic [7:0]  exp_regs [8];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned last_bv_cyc = 0;
    int unsigned s4_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ev(input ev_kind_t k, input int unsigned idx, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.idx  = idx;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_event(input ev_kind_t kind, input logic [7:0] bdata,
                               input logic [7:0] stb, input logic [63:0] regs);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got data %0h stb %0h expected no output",
                     kind.name(), bdata, stb);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind) begin
            errors++;
            $display("FAIL event_order: got %s expected %s", kind.name(), e.kind.name());
            return;
        end
        case (kind)
            EV_BV: begin
                last_bv_cyc = cyc;
                if (bdata !== e.data) begin
                    errors++;
                    $display("FAIL byte_data: got %0h expected %0h", bdata, e.data);
                end
            end
            EV_WR: begin
                if (stb !== (8'h01 << e.idx)) begin
                    errors++;
                    $display("FAIL wr_stb: got %0h expected %0h", stb, 8'h01 << e.idx);
                end
                check_val("wr_value", 64'(regs[8*e.idx +: 8]), 64'(e.data));
                check_val("wr_latency", 64'(cyc - last_bv_cyc), 64'd1);
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus8.byte_valid)     check_event(EV_BV, bus8.byte_data, 8'h00, bus8.regs);
            if (bus8.frame_err)      check_event(EV_FE, 8'h00, 8'h00, bus8.regs);
            if (bus8.wr_stb != '0)   check_event(EV_WR, 8'h00, bus8.wr_stb, bus8.regs);
            if (bus4.wr_stb != '0)   s4_cnt++;
        end
    end

    task automatic idle(input int unsigned bits);
        bus8.rx = 1'b1;
        repeat (bits * BITCLK) @(negedge clk);
    endtask

    task automatic tx_raw(input logic [7:0] b, input logic stop);
        bus8.rx = 1'b0;
        repeat (BITCLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus8.rx = b[i];
            repeat (BITCLK) @(negedge clk);
        end
        bus8.rx = stop;
        repeat (BITCLK) @(negedge clk);
    endtask

    task automatic tx_byte(input logic [7:0] b);
        push_ev(EV_BV, 0, b);
        tx_raw(b, 1'b1);
        idle(1);
    endtask

    task automatic tx_pair(input logic [7:0] lo, input logic [7:0] hi, input int unsigned gap,
                           input int unsigned idx, input logic [7:0] val);
        push_ev(EV_BV, 0, lo);
        tx_raw(lo, 1'b1);
        idle(gap);
        push_ev(EV_BV, 0, hi);
        push_ev(EV_WR, idx, val);
        exp_regs[idx] = val;
        tx_raw(hi, 1'b1);
        idle(1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 * BITCLK && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: got %0d pending events expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_regs(input string name);
        logic [63:0] r;
        r = bus8.regs;
        for (int i = 0; i < 8; i++)
            check_val($sformatf("%s_reg%0d", name, i), 64'(r[8*i +: 8]), 64'(exp_regs[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned s4_before;
        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
        bus8.rx = 1'b1;
        rst_n   = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rst_regs",       64'(bus8.regs),       64'h0);
        check_val("rst_wr_stb",     64'(bus8.wr_stb),     64'h0);
        check_val("rst_byte_valid", 64'(bus8.byte_valid), 64'h0);
        check_val("rst_byte_data",  64'(bus8.byte_data),  64'h0);
        check_val("rst_frame_err",  64'(bus8.frame_err),  64'h0);
        rst_n = 1'b1;
        idle(2);

        // Basic pair
        tx_pair(8'h02, 8'h18, 1, 0, 8'h82);
        drain("pair");
        check_regs("pair");

        // Eight-byte stream
        tx_pair(8'h27, 8'h3A, 1, 1, 8'hA7);
        tx_pair(8'h02, 8'h18, 1, 0, 8'h82);
        tx_pair(8'h4C, 8'h57, 1, 2, 8'h7C);
        tx_pair(8'h69, 8'h70, 1, 3, 8'h09);
        drain("stream");
        check_regs("stream");

        // Orphans and mismatches: no writes expected
        tx_byte(8'h3A);
        tx_byte(8'h27);
        tx_byte(8'h1F);
        tx_byte(8'h3A);
        drain("orphan");
        check_regs("orphan");

        // 0.3-bit glitch
        bus8.rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(3);
        drain("glitch");

        // Framing error followed by a 30-bit break
        push_ev(EV_FE, 0, 8'h00);
        tx_raw(8'h27, 1'b0);
        bus8.rx = 1'b0;
        repeat (30 * BITCLK) @(negedge clk);
        idle(2);
        tx_pair(8'h27, 8'h3A, 1, 1, 8'hA7);
        drain("break");
        check_regs("break");

        // Timeout: long gap drops staged nibble, short gap keeps it
        tx_byte(8'h23);
        idle(24);
        tx_byte(8'h39);
        drain("timeout_long");
        check_regs("timeout_long");
        tx_pair(8'h23, 8'h39, 8, 1, 8'h93);
        drain("timeout_short");
        check_regs("timeout_short");

        // Index beyond a 4-register instance
        s4_before = s4_cnt;
        tx_pair(8'h8F, 8'h9F, 1, 4, 8'hFF);
        drain("idx4");
        check_regs("idx4");
        check_val("small_no_strobe", 64'(s4_cnt - s4_before), 64'h0);
        check_val("small_regs", 64'(bus4.regs), 64'h097C_9382);

        // Reset in the middle of a byte
        bus8.rx = 1'b0;
        repeat (3 * BITCLK + 5) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("midrst_regs",       64'(bus8.regs),       64'h0);
        check_val("midrst_byte_data",  64'(bus8.byte_data),  64'h0);
        check_val("midrst_byte_valid", 64'(bus8.byte_valid), 64'h0);
        check_val("midrst_small_regs", 64'(bus4.regs),       64'h0);
        bus8.rx = 1'b1;
        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        tx_pair(8'h02, 8'h18, 1, 0, 8'h82);
        drain("after_reset");
        check_regs("after_reset");
        check_val("after_reset_small", 64'(bus4.regs), 64'h0000_0082);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
